// File: rtl/shared_cell_arbiter.sv
// Round-robin REQ/GNT/DONE arbiter for one shared datapath resource.
// Define ARB_TIMEOUT_EN to add a watchdog that forces release after TMO_CYCLES of ownership.
module shared_cell_arbiter #(
  parameter int N          = 4,
  parameter int TMO_CYCLES = 16,
  localparam int IDW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           r,
  input  logic [N-1:0]   req,
  input  logic           done,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           busy,
  output logic           tmo
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN  = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  logic [1:0]     state;
  logic [IDW-1:0] ptr;
  logic           win_found;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] ptr_next;
  logic [IDW:0]   cand;
  logic [IDW:0]   nxt;
  logic           release_norm;
  logic           release_any;

  // Scan upward from ptr with wrap; the extra bit keeps ptr+i from overflowing before the wrap.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(N)) cand = cand - (IDW+1)'(N);
      if (!win_found && req[cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[IDW-1:0];
      end
    end
    nxt = {1'b0, win_id} + (IDW+1)'(1);
    if (nxt >= (IDW+1)'(N)) nxt = '0;
    ptr_next = nxt[IDW-1:0];
  end

  // Owner withdrawing its request counts as a release just like DONE.
  assign release_norm = done | ~req[gnt_id];
  assign busy         = |gnt;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TMO_CYCLES);

  logic [CW-1:0] cnt;
  logic          expire;

  assign expire      = (cnt == CW'(TMO_CYCLES - 1));
  assign release_any = release_norm | expire;

  // DONE on the expiry edge wins, so the pulse only marks a genuinely forced release.
  always_ff @(posedge clk) begin
    if (r) begin
      cnt <= '0;
      tmo <= 1'b0;
    end else begin
      tmo <= 1'b0;
      if (state != OWN) begin
        cnt <= '0;
      end else if (release_any) begin
        tmo <= expire & ~release_norm;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
`else
  assign release_any = release_norm;
  assign tmo         = 1'b0;
`endif

  // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (r) begin
      state  <= IDLE;
      gnt    <= '0;
      gnt_id <= '0;
      ptr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state  <= OWN;
            gnt    <= N'(1) << win_id;
            gnt_id <= win_id;
            ptr    <= ptr_next;
          end
        end
        OWN: begin
          if (release_any) begin
            state  <= GAP;
            gnt    <= '0;
            gnt_id <= '0;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_cell_arbiter.sv
// Scoreboard bench for shared_cell_arbiter: a cycle-level reference model queues expected outputs,
// a negedge monitor pops and compares them. Honours ARB_TIMEOUT_EN the same way the design does.
module tb_shared_cell_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int TMO = 16;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           r;
  logic [N-1:0]   req;
  logic           done;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;
  logic           tmo;

  always #5 clk = ~clk;

  shared_cell_arbiter #(.N(N), .TMO_CYCLES(TMO)) dut (
    .clk    (clk),
    .r      (r),
    .req    (req),
    .done   (done),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy),
    .tmo    (tmo)
  );

  typedef struct packed {
    logic [N-1:0]   gnt;
    logic [IDW-1:0] id;
    logic           busy;
    logic           tmo;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  string phase  = "reset";

  // Reference model: owner index (-1 none), last grantee, dead edges left, cycles owned.
  int m_owner = -1;
  int m_last  = N - 1;
  int m_wait  = 0;
  int m_hold  = 0;
  bit m_tmo   = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic void model_edge(input logic rr, input logic [N-1:0] rq, input logic dn);
    bit found;
    m_tmo = 1'b0;
    if (rr) begin
      m_owner = -1;
      m_last  = N - 1;
      m_wait  = 0;
      m_hold  = 0;
    end else if (m_owner >= 0) begin
      m_hold++;
      if (dn || !rq[m_owner]) begin
        m_owner = -1;
        m_wait  = 1;
      end else if (TO_EN && m_hold == TMO) begin
        m_owner = -1;
        m_wait  = 1;
        m_tmo   = 1'b1;
      end
    end else if (m_wait > 0) begin
      m_wait--;
    end else begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (!found && rq[c]) begin
          found   = 1'b1;
          m_owner = c;
          m_last  = c;
          m_hold  = 0;
        end
      end
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.gnt  = (m_owner >= 0) ? N'(1) << m_owner : '0;
    e.id   = (m_owner >= 0) ? IDW'(m_owner) : '0;
    e.busy = (m_owner >= 0);
    e.tmo  = m_tmo;
    return e;
  endfunction

  task automatic step(input logic rr, input logic [N-1:0] rq, input logic dn);
    r    = rr;
    req  = rq;
    done = dn;
    @(posedge clk);
    model_edge(rr, rq, dn);
    exp_q.push_back(model_out());
    tag_q.push_back($sformatf("%s@%0d", phase, cyc));
    cyc++;
    @(negedge clk);
  endtask

  // Monitor: compares whatever the stimulus has queued against the DUT, away from the active edge.
  initial begin
    exp_t  e;
    exp_t  got;
    string t;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        got = {gnt, gnt_id, busy, tmo};
        check({t, " gnt/id/busy/tmo"}, 64'(got), 64'(e));
        check({t, " onehot"}, 64'($onehot0(gnt)), 64'(1));
        check({t, " busy_or"}, 64'(busy), 64'(|gnt));
      end
    end
  end

  initial begin
    int         run;
    int         pd;
    logic [N-1:0] rq;
    logic         dn;
    logic         rr;
    int         rr_ids[4];
    rr_ids = '{1, 2, 3, 0};
    r = 1'b1;
    req = '0;
    done = 1'b0;

    phase = "reset";
    step(1, 4'b1111, 0);
    step(1, 4'b1111, 0);
    check("reset_busy", 64'(busy), 64'(0));
    step(0, 4'b1111, 0);
    check("first_grant", 64'(gnt), 64'(4'b0001));

    phase = "round_robin";
    for (int g = 0; g < 4; g++) begin
      step(0, 4'b1111, 1);
      check("rr_gap1", 64'(gnt), 64'(0));
      step(0, 4'b1111, 0);
      check("rr_gap2", 64'(gnt), 64'(0));
      step(0, 4'b1111, 0);
      check("rr_order", 64'(gnt_id), 64'(rr_ids[g]));
    end
    step(0, 4'b1111, 1);
    step(0, 4'b0000, 0);
    step(0, 4'b0000, 0);

    phase = "skip_wrap";
    step(0, 4'b0100, 0);
    check("skip_grant2", 64'(gnt_id), 64'(2));
    step(0, 4'b0100, 1);
    step(0, 4'b0011, 0);
    step(0, 4'b0011, 0);
    check("wrap_to_0", 64'(gnt_id), 64'(0));
    step(0, 4'b0011, 1);
    step(0, 4'b0011, 0);
    step(0, 4'b0011, 0);
    check("ptr_after_wrap", 64'(gnt_id), 64'(1));

    phase = "withdraw";
    step(0, 4'b0001, 0);
    check("withdraw_release", 64'(busy), 64'(0));
    step(0, 4'b0000, 1);
    step(0, 4'b0000, 1);
    step(0, 4'b0000, 1);
    check("done_idle_ignored", 64'(busy), 64'(0));

    phase = "mid_reset";
    step(0, 4'b0100, 0);
    check("mid_grant2", 64'(gnt_id), 64'(2));
    step(1, 4'b0100, 1);
    check("mid_reset_gnt", 64'(gnt), 64'(0));
    step(0, 4'b0100, 0);
    check("regrant2", 64'(gnt_id), 64'(2));
    step(1, 4'b1001, 0);
    check("reset_beats_req", 64'(busy), 64'(0));
    step(0, 4'b1001, 0);
    check("ptr_reset_to_0", 64'(gnt_id), 64'(0));
    step(0, 4'b0000, 1);
    step(0, 4'b0000, 0);
    step(0, 4'b0000, 0);

    phase = "timeout";
    step(0, 4'b1000, 0);
    check("tmo_grant3", 64'(gnt), 64'(4'b1000));
    run = 1;
    for (int i = 0; i < 120 && gnt[3]; i++) begin
      step(0, 4'b1000, 0);
      if (gnt[3]) run++;
    end
    if (TO_EN) begin
      check("tmo_hold_len", 64'(run), 64'(TMO));
      check("tmo_pulse", 64'(tmo), 64'(1));
      step(0, 4'b1000, 0);
      check("tmo_one_cycle", 64'(tmo), 64'(0));
    end else begin
      check("hold_over_100", 64'(run > 100), 64'(1));
      check("tmo_stays_0", 64'(tmo), 64'(0));
    end
    step(0, 4'b0000, 1);
    step(0, 4'b0000, 0);
    step(0, 4'b0000, 0);

    rq = '0;
    for (int ph = 0; ph < 3; ph++) begin
      phase = $sformatf("random%0d", ph);
      pd = (ph == 0) ? 40 : ((ph == 1) ? 8 : 1);
      for (int i = 0; i < 1000; i++) begin
        if ($urandom_range(0, 3) == 0) rq[$urandom_range(0, N-1)] ^= 1'b1;
        dn = ($urandom_range(0, 99) < pd);
        rr = ($urandom_range(0, 199) == 0);
        step(rr, rq, dn);
      end
    end

    repeat (2) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shared_cell_arbiter.md
# shared_cell_arbiter

Round-robin arbiter that grants exclusive use of one shared datapath resource (e.g. a shared XOR2X1/AND2X2-built operator or a DFFSR-backed register bank) to one of N requesters at a time. It sits between the requesting blocks and the resource's select/enable logic. Requesters use a REQ/GNT/DONE handshake. An optional watchdog forces release of a grant that is held too long.

## Interface
- N, default 4: number of requesters, 2..16.
- TMO_CYCLES, default 16: watchdog limit in cycles of continuous ownership, ≥2. Used only with ARB_TIMEOUT_EN.
- IDW, default $clog2(N): width of GNT_ID. Derived; do not override.

Ports:
- CLK  in  1  rising-edge clock; the only clock.
- R  in  1  reset; synchronous, active-high.
- REQ  in  N  per-requester request level.
- DONE  in  1  owner signals end of use; qualified by BUSY.
- GNT  out  N  one-hot grant, registered.
- GNT_ID  out  IDW  binary index of current grantee; 0 when idle.
- BUSY  out  1  high while a grant is held.
- TMO  out  1  one-cycle pulse on forced release.

## Operation
- FSM states and transitions:
  - IDLE → OWN when any REQ bit is set.
  - OWN → GAP on release.
  - GAP → IDLE unconditionally.
- Reset (R=1 at an edge), from any state, including mid-grant: state=IDLE, GNT=0, GNT_ID=0, BUSY=0, TMO=0, priority pointer PTR=0, watchdog count=0.
- Arbitration happens in IDLE only:
  - Winner is the first set REQ bit scanning upward from PTR, wrapping from N-1 to 0.
  - On grant, PTR becomes winner+1 mod N, so the last grantee has lowest priority next time.
- Release from OWN happens on whichever comes first at a clock edge:
  - DONE=1;
  - REQ[owner]=0 (requester withdrew);
  - watchdog expiry (macro only).
- DONE while not BUSY is ignored.
- REQ changes of non-owners during OWN and GAP are ignored. They are re-sampled in IDLE.
- GAP is a mandatory dead cycle. It guarantees GNT is all-zero for at least one cycle between owners, including the same requester re-winning.
- GNT is always one-hot or zero. BUSY equals the OR of GNT.

## Timing
- Grant latency: REQ set before edge t while in IDLE gives GNT high after edge t (visible in cycle t+1).
- Release: DONE sampled at edge k gives GNT/BUSY low after edge k. State is GAP in the next cycle, IDLE in the one after.
- The next grant appears after edge k+2.
- Minimum owner-to-owner turnaround: 2 cycles of GNT=0.
- Single requester holding REQ high and pulsing DONE gets a grant every 3rd edge pair: 1 cycle OWN minimum, then GAP, IDLE, OWN.
- If DONE and REQ[owner] drop at the same edge: one release, same behaviour as DONE.
- R asserted simultaneously with DONE or a request: reset wins, and no grant is issued that edge.
- N=2 wrap: PTR alternates 0/1. PTR never exceeds N-1.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A counter clears on entry to OWN and increments each cycle in OWN.
  - If it reaches TMO_CYCLES-1 with no other release, the next edge releases the grant and TMO=1 for exactly the GAP cycle.
  - PTR is updated as for a normal release.
  - DONE at the expiry edge counts as a normal release, with TMO=0.
- ARB_TIMEOUT_EN undefined: no counter is present, TMO is tied 0, and a grant is held until DONE or REQ withdrawal.

## Test plan
- Reset: hold R=1 for 2 cycles with REQ=4'b1111 -> GNT=0, GNT_ID=0, BUSY=0, TMO=0. After release, the first grant goes to requester 0 on the next edge.
- Round-robin: REQ=4'b1111 held, DONE pulsed 1 cycle after each grant -> grant order 0,1,2,3,0. GNT is zero for 2 cycles between each grant.
- Priority skip and wrap: PTR=3 after a grant to 2, REQ=4'b0011 -> grant to 0 (not 1), then PTR=1.
- Withdrawal: grant to 1, drop REQ[1] without DONE -> GNT low next edge. DONE asserted while idle has no effect.
- Mid-grant reset: assert R during OWN with GNT_ID=2 -> all outputs 0 after that edge and PTR=0. With REQ=4'b0100 held, a fresh grant to 2 follows.
- Timeout (ARB_TIMEOUT_EN, TMO_CYCLES=16): REQ[3] held, no DONE -> GNT[3] high for exactly 16 cycles, then TMO=1 for 1 cycle. Without the macro, the grant persists more than 100 cycles and TMO stays 0.
